// File: rtl/count_uart_tx_if.sv
// Byte stream handshake into the counter UART transmitter.
// The producer drives data and valid; the transmitter returns ready.
interface count_uart_tx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/count_uart_tx.sv
// UART 8N1 transmitter for counter samples.
// Bytes are buffered in a small FIFO before serialisation.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    count_uart_tx_if.slave              in_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic [7:0]      shift;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic            line_busy;
    logic            push;
    logic            pop;
    logic            baud_done;

    assign in_if.in_ready = rst_n && (level != FULL);
    assign push           = in_if.in_valid && in_if.in_ready;
    assign pop            = (state == IDLE) && (level != '0);
    assign baud_done      = (baud == BAUD_LAST);
    assign fifo_level     = level;
    // line_busy covers the stop bit still on the pin after the FSM is idle
    assign busy = (state != IDLE) || (level != '0) || line_busy;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_if.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            shift     <= '0;
            baud      <= '0;
            bit_idx   <= '0;
            tx        <= 1'b1;
            line_busy <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase

            // pin follows the state one cycle later, straight from a flop
            unique case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase
            line_busy <= (state != IDLE);

            unique case (state)
                IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud    <= '0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
